// File: rtl/fifo_serial_tx.sv
// Drains a first-word-fall-through FIFO one word at a time and sends each word
// LSB-first as an async serial frame: start, data, optional even parity, stop bit(s).
module fifo_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_data_i,
    output logic              fifo_pop_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [15:0]       words_sent_o
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t              state, state_n;
    logic [BAUD_W-1:0]   baud, baud_n;
    logic [BIT_W-1:0]    bit_cnt, bit_n;
    logic [DATA_W-1:0]   shift, shift_n;
    logic                parity, parity_n;
    logic                tx_n;
    logic                baud_last;
    logic                stop_last;

    assign baud_last = (baud == BAUD_LAST);
    assign stop_last = (state == STOP) && (bit_cnt == LAST_STOP) && baud_last;

    // Gated by reset so a frame aborted in its final cycle neither pops nor reports done.
    assign fifo_pop_o   = reset & enable_i & ~fifo_empty_i & ((state == IDLE) | stop_last);
    assign frame_done_o = reset & stop_last;
    assign busy_o       = (state != IDLE);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_n  = state;
        baud_n   = baud;
        bit_n    = bit_cnt;
        shift_n  = shift;
        parity_n = parity;

        if (fifo_pop_o) begin
            state_n  = START;
            baud_n   = '0;
            bit_n    = '0;
            shift_n  = fifo_data_i;
            parity_n = ^fifo_data_i;
        end else if (state != IDLE) begin
            baud_n = baud_last ? '0 : baud + 1'b1;
            if (baud_last) begin
                case (state)
                    START: begin
                        state_n = DATA;
                        bit_n   = '0;
                    end
                    DATA: begin
                        if (bit_cnt == LAST_DATA) begin
                            state_n = (PARITY_EN != 0) ? PARITY : STOP;
                            bit_n   = '0;
                        end else begin
                            bit_n   = bit_cnt + 1'b1;
                            shift_n = shift >> 1;
                        end
                    end
                    PARITY: begin
                        state_n = STOP;
                        bit_n   = '0;
                    end
                    STOP: begin
                        if (bit_cnt == LAST_STOP) begin
                            state_n = IDLE;
                            bit_n   = '0;
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end

        // Line level is derived from the next state so tx_o leaves a flop cleanly.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = parity_n;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state        <= IDLE;
            baud         <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            parity       <= 1'b0;
            tx_o         <= 1'b1;
            words_sent_o <= '0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            parity  <= parity_n;
            tx_o    <= tx_n;
            if (stop_last) words_sent_o <= words_sent_o + 16'd1;
        end
    end

endmodule
